// File: rtl/mux8_serializer.sv
// Parallel-to-serial front end for an external 8:1 mux: holds a word on the mux
// inputs, walks the select lines through all eight positions and registers Q.
module mux8_serializer #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] mux_data,
    output logic [2:0] mux_sel,
    input  logic       mux_q,
    output logic       dout,
    output logic       dout_valid,
    output logic       dout_last,
    input  logic       dout_ready
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [2:0] FIRST_SEL = LSB_FIRST ? 3'd0 : 3'd7;

    state_e     state_q, state_d;
    logic [7:0] mux_data_q, mux_data_d;
    logic [2:0] mux_sel_q, mux_sel_d;
    logic [2:0] cnt_q, cnt_d;
    logic       dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       dout_last_q, dout_last_d;

    logic load;
    logic accept;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d      = state_q;
        mux_data_d   = mux_data_q;
        mux_sel_d    = mux_sel_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;

        // The output register may be refilled when it is empty or being drained.
        load      = (state_q == SHIFT) && (!dout_valid_q || dout_ready);
        din_ready = (state_q == IDLE) || (load && (cnt_q == 3'd7));
        accept    = din_valid && din_ready;

        case (state_q)
            IDLE: begin
                mux_sel_d = FIRST_SEL;
                if (dout_valid_q && dout_ready) begin
                    dout_valid_d = 1'b0;
                end
                if (accept) begin
                    mux_data_d = din;
                    cnt_d      = 3'd0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (load) begin
                    dout_d       = mux_q;
                    dout_valid_d = 1'b1;
                    dout_last_d  = (cnt_q == 3'd7);
                    if (cnt_q != 3'd7) begin
                        cnt_d     = cnt_q + 3'd1;
                        mux_sel_d = LSB_FIRST ? (mux_sel_q + 3'd1) : (mux_sel_q - 3'd1);
                    end else if (accept) begin
                        // Chain straight into the next word without a bubble.
                        mux_data_d = din;
                        cnt_d      = 3'd0;
                        mux_sel_d  = FIRST_SEL;
                    end else begin
                        mux_sel_d = FIRST_SEL;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mux_data_q   <= 8'h00;
            mux_sel_q    <= 3'd0;
            cnt_q        <= 3'd0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mux_data_q   <= mux_data_d;
            mux_sel_q    <= mux_sel_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    assign mux_data   = mux_data_q;
    assign mux_sel    = mux_sel_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;

endmodule

// File: tb/tb_mux8_serializer.sv
// Directed bench for mux8_serializer: one LSB-first and one MSB-first instance,
// each closing the loop through a behavioural 8:1 mux.
module tb_mux8_serializer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;

    logic [7:0] din_a = 8'h00;
    logic       din_valid_a = 1'b0;
    logic       din_ready_a;
    logic [7:0] mux_data_a;
    logic [2:0] mux_sel_a;
    logic       mux_q_a;
    logic       dout_a, dout_valid_a, dout_last_a;
    logic       dout_ready_a = 1'b1;

    logic [7:0] din_b = 8'h00;
    logic       din_valid_b = 1'b0;
    logic       din_ready_b;
    logic [7:0] mux_data_b;
    logic [2:0] mux_sel_b;
    logic       mux_q_b;
    logic       dout_b, dout_valid_b, dout_last_b;
    logic       dout_ready_b = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mux_q_a = mux_data_a[mux_sel_a];
    assign mux_q_b = mux_data_b[mux_sel_b];

    mux8_serializer #(.LSB_FIRST(1'b1)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(din_valid_a),
        .din_ready(din_ready_a), .mux_data(mux_data_a), .mux_sel(mux_sel_a),
        .mux_q(mux_q_a), .dout(dout_a), .dout_valid(dout_valid_a),
        .dout_last(dout_last_a), .dout_ready(dout_ready_a)
    );

    mux8_serializer #(.LSB_FIRST(1'b0)) u_dut_msb (
        .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(din_valid_b),
        .din_ready(din_ready_b), .mux_data(mux_data_b), .mux_sel(mux_sel_b),
        .mux_q(mux_q_b), .dout(dout_b), .dout_valid(dout_valid_b),
        .dout_last(dout_last_b), .dout_ready(dout_ready_b)
    );

    // Observed vector layout: {mux_data, mux_sel, dout, dout_valid, dout_last, din_ready}
    task automatic test_reset();
        logic [14:0] exp;
        #1 rst_n = 1'b0;
        #2;
        exp = {8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if ({mux_data_a, mux_sel_a, dout_a, dout_valid_a, dout_last_a, din_ready_a} !== exp) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h",
                     {mux_data_a, mux_sel_a, dout_a, dout_valid_a, dout_last_a, din_ready_a}, exp);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Caller sits at a negedge; the word is accepted on the next rising edge.
    task automatic test_word(input logic [7:0] w);
        logic [6:0] exp;
        din_a        = w;
        din_valid_a  = 1'b1;
        dout_ready_a = 1'b1;
        checks++;
        if (din_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL word_%h_ready_idle: got %b expected 1", w, din_ready_a);
        end
        @(negedge clk);
        din_valid_a = 1'b0;
        checks++;
        if ({mux_data_a, mux_sel_a, dout_valid_a} !== {w, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL word_%h_load: got data %h sel %0d valid %b expected %h 0 0",
                     w, mux_data_a, mux_sel_a, dout_valid_a, w);
        end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            exp = {(n < 7) ? 3'(n + 1) : 3'd0, 1'b1, w[n], (n == 7), (n >= 6)};
            checks++;
            if ({mux_sel_a, dout_valid_a, dout_a, dout_last_a, din_ready_a} !== exp) begin
                errors++;
                $display("FAIL word_%h_bit%0d: got sel/valid/dout/last/ready %b expected %b",
                         w, n, {mux_sel_a, dout_valid_a, dout_a, dout_last_a, din_ready_a}, exp);
            end
        end
        @(negedge clk);
        checks++;
        if ({dout_valid_a, din_ready_a} !== 2'b01) begin
            errors++;
            $display("FAIL word_%h_drain: got valid/ready %b expected 01", w,
                     {dout_valid_a, din_ready_a});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        logic [3:0]  exp;
        bits = 16'h0FFF;
        din_a       = 8'hFF;
        din_valid_a = 1'b1;
        @(negedge clk);
        checks++;
        if (din_ready_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_after_accept: got %b expected 0", din_ready_a);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp = {1'b1, bits[i], (i == 7) || (i == 15), (i == 6) || (i == 14) || (i == 15)};
            checks++;
            if ({dout_valid_a, dout_a, dout_last_a, din_ready_a} !== exp) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got valid/dout/last/ready %b expected %b",
                         i, {dout_valid_a, dout_a, dout_last_a, din_ready_a}, exp);
            end
            if (i == 6)  din_a = 8'h0F;
            if (i == 14) din_valid_a = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (dout_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got valid %b expected 0", dout_valid_a);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] w;
        logic [5:0] exp;
        w = 8'h3C;
        din_a       = w;
        din_valid_a = 1'b1;
        @(negedge clk);
        din_valid_a = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            exp = {(n < 7) ? 3'(n + 1) : 3'd0, 1'b1, w[n], (n == 7)};
            checks++;
            if ({mux_sel_a, dout_valid_a, dout_a, dout_last_a} !== exp) begin
                errors++;
                $display("FAIL bp_bit%0d: got sel/valid/dout/last %b expected %b",
                         n, {mux_sel_a, dout_valid_a, dout_a, dout_last_a}, exp);
            end
            if (n == 2) begin
                dout_ready_a = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    checks++;
                    if ({mux_sel_a, dout_valid_a, dout_a, dout_last_a, din_ready_a} !== 7'b0111100) begin
                        errors++;
                        $display("FAIL bp_stall%0d: got sel/valid/dout/last/ready %b expected 0111100",
                                 s, {mux_sel_a, dout_valid_a, dout_a, dout_last_a, din_ready_a});
                    end
                end
                dout_ready_a = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_msb_first();
        logic [6:0] exp;
        din_b       = 8'h80;
        din_valid_b = 1'b1;
        @(negedge clk);
        din_valid_b = 1'b0;
        checks++;
        if ({mux_data_b, mux_sel_b} !== {8'h80, 3'd7}) begin
            errors++;
            $display("FAIL msb_load: got data %h sel %0d expected 80 7", mux_data_b, mux_sel_b);
        end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            exp = {(n < 7) ? 3'(6 - n) : 3'd7, 1'b1, (n == 0), (n == 7), (n >= 6)};
            checks++;
            if ({mux_sel_b, dout_valid_b, dout_b, dout_last_b, din_ready_b} !== exp) begin
                errors++;
                $display("FAIL msb_bit%0d: got sel/valid/dout/last/ready %b expected %b",
                         n, {mux_sel_b, dout_valid_b, dout_b, dout_last_b, din_ready_b}, exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [14:0] exp;
        din_a       = 8'hAA;
        din_valid_a = 1'b1;
        @(negedge clk);
        din_valid_a = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({mux_sel_a, dout_valid_a, dout_a} !== {3'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL abort_bit4: got sel %0d valid %b dout %b expected 5 1 0",
                     mux_sel_a, dout_valid_a, dout_a);
        end
        #2 rst_n = 1'b0;
        #1;
        exp = {8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        checks++;
        if ({mux_data_a, mux_sel_a, dout_a, dout_valid_a, dout_last_a, din_ready_a} !== exp) begin
            errors++;
            $display("FAIL abort_reset: got %h expected %h",
                     {mux_data_a, mux_sel_a, dout_a, dout_valid_a, dout_last_a, din_ready_a}, exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_word(8'h01);
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_word(8'hA5);
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_backpressure();
        test_msb_first();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mux8_serializer.md
# mux8_serializer

Parallel-to-serial front end for the 8:1 mux stage. It accepts an 8-bit word over a valid/ready handshake and holds it on the mux data inputs A..H. It then steps the S2..S0 select lines through all eight positions and registers the mux output Q into a serial bit stream with valid/ready/last. Sits directly upstream (data, selects) and downstream (Q capture) of one mux8x0 instance in PP3 fabric test designs.

## Interface
- LSB_FIRST, 1, 1: select order 0..7 (A first); 0: order 7..0 (H first)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- din  in  8  parallel word; bit i drives mux input i (A=bit0 … H=bit7)
- din_valid  in  1  word offered
- din_ready  out  1  word accepted on edge where din_valid && din_ready
- mux_data  out  8  registered word to mux inputs A..H
- mux_sel  out  3  registered {S2,S1,S0} to mux
- mux_q  in  1  mux output Q (combinational from mux_data/mux_sel)
- dout  out  1  serial bit
- dout_valid  out  1  dout holds a bit
- dout_last  out  1  dout is bit 8 of 8 of its word
- dout_ready  in  1  downstream accepts dout when dout_valid && dout_ready

## Operation
- States: IDLE, SHIFT.
- Reset (async, immediate on rst_n low): state IDLE, mux_data=0, mux_sel=0, cnt=0, dout=0, dout_valid=0, dout_last=0. din_ready=1 as soon as IDLE is reached.
- din_ready = (state==IDLE) || (state==SHIFT && load && cnt==7). Combinational from state, cnt and dout_ready.
- load = state==SHIFT && (!dout_valid || dout_ready). This is the output-register enable.
- IDLE: mux_sel=first index (0 if LSB_FIRST, else 7). On accept: mux_data<=din, cnt<=0, mux_sel<=first index, go to SHIFT.
- SHIFT, on load:
  - dout<=mux_q, dout_valid<=1, dout_last<=(cnt==7).
  - If cnt<7: cnt<=cnt+1 and mux_sel steps (+1 if LSB_FIRST, −1 otherwise).
  - If cnt==7 with din_valid: accept the next word (mux_data, cnt=0, mux_sel=first) and stay in SHIFT, with no bubble.
  - If cnt==7 without din_valid: go to IDLE.
- SHIFT, no load (stall): mux_data, mux_sel, cnt, dout, dout_last all hold.
- Output drain: in IDLE, or in SHIFT without load, dout_valid clears on dout_valid && dout_ready. A pending bit is never dropped or overwritten.
- cnt is 3-bit, 0..7, and never wraps without a word boundary.
- mux_sel is derived from cnt: cnt when LSB_FIRST, 7−cnt otherwise.
- din is ignored while din_ready=0. mux_q is sampled only on load.

## Timing
- Word accepted at edge k: mux_data/mux_sel valid after k.
- With dout_ready=1:
  - First bit has dout_valid=1 after edge k+1.
  - Bit n (n=0..7) is presented after edge k+1+n.
  - dout_last is high after edge k+8.
- Back-to-back words: the next word is accepted at edge k+8, and its first bit follows at k+9. Sustained rate is 1 bit/cycle.
- Each cycle of dout_ready low while dout_valid adds exactly 1 cycle. mux_sel is stable throughout a stall.
- The mux_q path is one combinational stage, mux_sel/mux_data reg → mux8 → dout reg, and must meet clk in one cycle.
- Reset deassertion: the first accept is possible on the first edge after rst_n rises.

## Test plan
- Reset: assert rst_n low mid-cycle → all outputs 0 immediately (din_ready 1 once IDLE), mux_sel=0.
- LSB_FIRST=1, din=0xA5, dout_ready=1, mux modelled as mux_data[mux_sel] → dout=1,0,1,0,0,1,0,1 on cycles k+1..k+8; dout_last only at k+8; din_ready back high at k+8.
- Back-to-back: 0xFF then 0x0F, din_valid held → 16 consecutive dout_valid cycles, bits 1×8 then 1,1,1,1,0,0,0,0; din_ready high exactly at accept edges.
- Backpressure: 0x3C, dout_ready low 3 cycles while bit 2 is presented → dout=1 and mux_sel=3 held 3 cycles; full sequence 0,0,1,1,1,1,0,0 intact; total 11 cycles.
- LSB_FIRST=0, din=0x80 → mux_sel 7,6,…,0; dout=1,0,0,0,0,0,0,0.
- rst_n low at bit 4 of 0xAA → outputs clear immediately. After release, a new word 0x01 serializes cleanly with no residue from the aborted word.
